alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised sequential ALU: the registered, handshaked successor to the team's combinational 16-bit adder ALU. It accepts one operation at a time over a valid/ready interface. Add, subtract and logic ops complete in one cycle; an unsigned multiply runs as an iterative shift-add over WIDTH cycles. The result and the status flags (sign, zero, carry, parity, overflow) are held stable until the consumer accepts them. The block sits between the instruction-issue logic and the register write-back stage of the datapath.

## Interface
- WIDTH, 16, operand and result width in bits; legal range 4..64.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; equals 1 only in IDLE and only while rst is low.
- op  input  3  opcode: 000 ADD, 001 ADC, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 PASS (z = x).
- x, y  input  WIDTH  operands, sampled on the accept edge only.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- z  output  WIDTH  result.
- sign, zero, carry, parity, overflow  output  1 each  status flags, registered together with z.

## Operation
- Accept: in_valid & in_ready at a rising edge. Inputs are ignored in every other cycle.
- States:
  - IDLE: accept → DONE for non-MUL ops; accept → MUL for MUL.
  - MUL: lasts exactly WIDTH cycles, then → DONE.
  - DONE: out_valid=1; out_ready → IDLE.
- Arithmetic is computed at WIDTH+1 bits:
  - ADD: x+y.
  - ADC: x+y+cf, where cf is the internal carry register.
  - SUB: x+~y+1. carry=1 means no borrow.
  - carry = bit WIDTH of the sum.
  - overflow = signed overflow: operand MSBs equal and result MSB different. For SUB the second operand is ~y.
- AND, OR, XOR, PASS: carry=0, overflow=0.
- MUL:
  - Unsigned, 2·WIDTH-bit accumulator, one shift-add step per MUL cycle.
  - z = low WIDTH bits of the product.
  - carry = 1 if any high product bit is set.
  - overflow = 0.
- Flags for every op:
  - sign = z[WIDTH-1].
  - zero = (z == 0).
  - parity = XNOR-reduction of z (1 when the count of ones is even).
- cf is loaded with the carry flag whenever a result is written, for every op. ADC uses the cf value present at its accept edge.
- Reset (any cycle, including mid-MUL or in DONE with an unconsumed result):
  - Next state is IDLE, cf=0, MUL counter and accumulator cleared.
  - In-flight result is discarded and never presented.

## Timing
- Reset values: z=0, sign=0, zero=0, carry=0, parity=0, overflow=0, out_valid=0. in_ready=0 during rst and 1 in the first cycle after rst deasserts.
- Latency, with the accept cycle as cycle 0:
  - Non-MUL: out_valid=1 in cycle 1.
  - MUL: out_valid=1 in cycle WIDTH+1 (17 for WIDTH=16).
- Between accept and the first out_valid cycle: out_valid=0 and in_ready=0. z and flags keep their previous values until the new result is written.
- While out_valid=1 and out_ready=0: z, flags and out_valid are held unchanged, and in_ready=0.
- Output handoff: out_valid & out_ready at an edge → IDLE.
  - out_valid=0 and in_ready=1 in the next cycle.
  - z and flags keep their last values after handoff. Only out_valid qualifies them.
- Maximum throughput is one non-MUL op every 2 cycles. There is no same-cycle output-drain-and-accept.
- out_ready while out_valid=0 has no effect.

## Test plan
All scenarios use WIDTH=16.

- Signed overflow: ADD 0x7FFF + 0x0001 → z=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0; out_valid in cycle 1.
- Carry chain: ADD 0xFFFF + 0x0001 → z=0x0000, zero=1, carry=1, parity=1. Then ADC 0x0001 + 0x0001 → z=0x0003, carry=0. Then ADC 0x0001 + 0x0001 → z=0x0002.
- Borrow: SUB 0x0003 − 0x0005 → z=0xFFFE, carry=0, sign=1, overflow=0, parity=0. SUB 0x8000 − 0x0001 → z=0x7FFF, overflow=1, carry=1.
- Multiply:
  - MUL 0x0100 × 0x0100 → z=0x0000, zero=1, carry=1; out_valid first high exactly in cycle 17.
  - MUL 0x00FF × 0x0003 → z=0x02FD, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after a XOR 0xF0F0 ^ 0x0FF0 (→ z=0xFF00, parity=1) while driving in_valid=1 with other operands. Required: z and flags stable, in_ready=0, no new accept. Raise out_ready → in_ready=1 in the next cycle.
- Reset mid-MUL:
  - Assert rst in cycle 5 of a MUL → out_valid=0 and all outputs 0 in cycle 6; in_ready=1 in the first cycle after release.
  - A following ADC 0x0001 + 0x0001 → z=0x0002, proving cf=0.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle add/sub/logic ops
// and a WIDTH-cycle shift-add unsigned multiply; result and flags held until consumed.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state, state_nx;
  logic               cf;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               mul_last;
  logic               wr;
  logic [WIDTH-1:0]   opb;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_z;
  logic               res_c;
  logic               res_v;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign mul_last  = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
  assign wr        = (accept && (op != OP_MUL)) || mul_last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    opb   = (op == OP_SUB) ? ~y : y;
    cin   = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? cf : 1'b0);
    sum   = {1'b0, x} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
    prod  = acc + (mplier[0] ? mcand : '0);
    res_z = sum[WIDTH-1:0];
    res_c = 1'b0;
    res_v = 1'b0;
    if (state == S_MUL) begin
      // Final shift-add step folds straight into the written result.
      res_z = prod[WIDTH-1:0];
      res_c = |prod[2*WIDTH-1:WIDTH];
    end else begin
      case (op)
        OP_ADD, OP_ADC, OP_SUB: begin
          res_c = sum[WIDTH];
          res_v = (x[MSB] == opb[MSB]) && (sum[MSB] != x[MSB]);
        end
        OP_AND:  res_z = x & y;
        OP_OR:   res_z = x | y;
        OP_XOR:  res_z = x ^ y;
        OP_PASS: res_z = x;
        default: res_z = sum[WIDTH-1:0];
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:   if (mul_last) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset also clears the
  // multiplier datapath so an aborted multiply leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cf       <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      z        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && (op == OP_MUL)) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, x};
        mplier <= y;
        cnt    <= '0;
      end else if (state == S_MUL) begin
        acc    <= prod;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
      if (wr) begin
        z        <= res_z;
        sign     <= res_z[MSB];
        zero     <= (res_z == '0);
        carry    <= res_c;
        parity   <= ~^res_z;
        overflow <= res_v;
        cf       <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized ops,
// checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] z;
  logic         sign, zero, carry, parity, overflow;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .sign(sign), .zero(zero), .carry(carry), .parity(parity), .overflow(overflow)
  );

  // Flag vector order: {sign, zero, carry, parity, overflow}
  typedef struct {
    logic [W-1:0] z;
    logic [4:0]   f;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   model_cf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = $signed(a);
    longint sb_ = $signed(b);
    longint s;
    longint ss;
    logic [W-1:0] r;
    logic c = 1'b0;
    logic v = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        s  = ua + ub + ((o == 3'd1) ? longint'(model_cf) : 0);
        ss = sa + sb_ + ((o == 3'd1) ? longint'(model_cf) : 0);
        r  = s[W-1:0];
        c  = (s >> W) != 0;
        v  = (ss > 32767) || (ss < -32768);
      end
      3'd2: begin
        ss = sa - sb_;
        r  = a - b;
        c  = (a >= b);
        v  = (ss > 32767) || (ss < -32768);
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin
        s = ua * ub;
        r = s[W-1:0];
        c = (s >> W) != 0;
      end
      default: r = a;
    endcase
    e.z = r;
    e.f = {r[W-1], r == '0, c, ($countones(r) % 2) == 0, v};
    return e;
  endfunction

  // Monitor: compares at every handoff against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got z=%h, expected no output (t=%0t)", z, $time);
      end else begin
        e = sb.pop_front();
        check("out_z", z, e.z);
        check("out_flags", {sign, zero, carry, parity, overflow}, e.f);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit junk);
    int   n;
    exp_t e;
    wait_idle();
    in_valid = 1'b1;
    op = o;
    x  = a;
    y  = b;
    e  = model(o, a, b);
    sb.push_back(e);
    model_cf = e.f[2];
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) check("busy_in_ready", in_ready, 0);
    end while (!out_valid && n < 40);
    check("latency", n, (o == 3'd6) ? W + 1 : 1);
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        in_valid = 1'b1;
        op = 3'($urandom_range(0, 7));
        x  = W'($urandom);
        y  = W'($urandom);
      end
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_z", z, e.z);
      check("hold_flags", {sign, zero, carry, parity, overflow}, e.f);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  task automatic dir(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ez, input logic [4:0] ef);
    do_op(o, a, b, 0, 1'b0);
    check("dir_z", z, ez);
    check("dir_flags", {sign, zero, carry, parity, overflow}, ef);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'hFFFF;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_flags", {sign, zero, carry, parity, overflow}, 0);

    dir(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b10001);
    dir(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b01110);
    dir(3'd1, 16'h0001, 16'h0001, 16'h0003, 5'b00010);
    dir(3'd1, 16'h0001, 16'h0001, 16'h0002, 5'b00000);
    dir(3'd2, 16'h0003, 16'h0005, 16'hFFFE, 5'b10000);
    dir(3'd2, 16'h8000, 16'h0001, 16'h7FFF, 5'b00101);
    dir(3'd6, 16'h0100, 16'h0100, 16'h0000, 5'b01110);
    dir(3'd6, 16'h00FF, 16'h0003, 16'h02FD, 5'b00010);

    // Backpressure with competing requests on the input side
    do_op(3'd5, 16'hF0F0, 16'h0FF0, 5, 1'b1);
    check("bp_z", z, 16'hFF00);
    check("bp_parity", parity, 1);
    repeat (2) begin
      @(negedge clk);
      check("bp_no_accept", out_valid, 0);
    end

    // Reset in cycle 5 of a multiply, with cf=1 beforehand
    dir(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b01110);
    wait_idle();
    in_valid = 1'b1;
    op = 3'd6;
    x  = 16'h1234;
    y  = 16'h5678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midmul_rst_in_ready", in_ready, 0);
    check("midmul_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_cf = 1'b0;
    @(negedge clk);
    check("midmul_out_valid", out_valid, 0);
    check("midmul_z", z, 0);
    check("midmul_flags", {sign, zero, carry, parity, overflow}, 0);
    check("midmul_in_ready", in_ready, 1);
    dir(3'd1, 16'h0001, 16'h0001, 16'h0002, 5'b00000);

    for (int i = 0; i < 80; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
